// File: rtl/sw_max_collector.sv
// ---------------------------------------------------------------------------
// sw_max_collector
//   Collects the running maximum score from the last PE of a Smith-Waterman
//   systolic chain over one or more stripe passes. The best score is kept
//   across passes, and the final score is presented with a valid/ready
//   handshake after the last stripe.
//
// Optional feature macro: SW_MAX_POS_EN
//   When defined, adds output max_pos_o. It holds the 1-based sample index
//   within the pass at which the accumulated score last strictly increased.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start_i        one-cycle pulse that begins a stripe pass (accepted in IDLE only)
//   new_align_i    sampled with start_i: clear the accumulated score first
//   last_pass_i    sampled with start_i: this pass is the final stripe
//   t_len_i        sampled with start_i: number of valid samples in the pass
//   init_in_i      last PE init_out, high on cycles that carry valid data
//   max_in_i       last PE MAX_out (unsigned running maximum)
//   score_ready_i  consumer accepts score_out_o
//   score_out_o    final alignment score
//   score_valid_o  score_out_o is valid
//   busy_o         FSM is not in IDLE
//   pass_done_o    one-cycle pulse when a pass completes
//   max_pos_o      (SW_MAX_POS_EN only) index of the last strict increase
// ---------------------------------------------------------------------------
module sw_max_collector #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              new_align_i,
  input  logic              last_pass_i,
  input  logic [LEN_W-1:0]  t_len_i,
  input  logic              init_in_i,
  input  logic [DATA_W-1:0] max_in_i,
  input  logic              score_ready_i,
  output logic [DATA_W-1:0] score_out_o,
  output logic              score_valid_o,
  output logic              busy_o,
  output logic              pass_done_o
`ifdef SW_MAX_POS_EN
  ,
  output logic [LEN_W-1:0]  max_pos_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    t_len_q, t_len_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  score_q, score_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_end;
  logic [LEN_W-1:0]    cnt_inc;

`ifdef SW_MAX_POS_EN
  logic [LEN_W-1:0]    pos_q, pos_d;
`else
  // Position tracking is compiled out in this build.
`endif

  // Index of the sample being captured this cycle (1-based).
  assign cnt_inc = cnt_q + LEN_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_len_q <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      score_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SW_MAX_POS_EN
      pos_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_len_q <= t_len_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SW_MAX_POS_EN
      pos_q   <= pos_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_len_d  = t_len_q;
    last_d   = last_q;
    acc_d    = acc_q;
    score_d  = score_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    pass_end = 1'b0;
`ifdef SW_MAX_POS_EN
    pos_d    = pos_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          t_len_d = t_len_i;
          last_d  = last_pass_i;
          cnt_d   = '0;
          if (new_align_i) begin
            acc_d = '0;
`ifdef SW_MAX_POS_EN
            pos_d = '0;
`endif
          end
          // A zero-length pass completes immediately without any samples.
          if (t_len_i == '0) begin
            pass_end = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT, COLLECT: begin
        if (init_in_i) begin
          cnt_d = cnt_inc;
          if (max_in_i > acc_q) begin
            acc_d = max_in_i;
`ifdef SW_MAX_POS_EN
            pos_d = cnt_inc;
`endif
          end
          if (cnt_inc == t_len_q) begin
            pass_end = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end

      DONE: begin
        if (valid_q && score_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Pass completion: last_d already reflects the freshly latched flag
    // when a zero-length pass ends straight out of IDLE.
    if (pass_end) begin
      done_d = 1'b1;
      if (last_d) begin
        state_d = DONE;
        valid_d = 1'b1;
        score_d = acc_d;
      end else begin
        state_d = IDLE;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign score_out_o   = score_q;
  assign score_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign pass_done_o   = done_q;
`ifdef SW_MAX_POS_EN
  assign max_pos_o     = pos_q;
`endif

endmodule

// File: tb/tb_sw_max_collector.sv
module tb_sw_max_collector;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned LEN_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              new_align_i;
  logic              last_pass_i;
  logic [LEN_W-1:0]  t_len_i;
  logic              init_in_i;
  logic [DATA_W-1:0] max_in_i;
  logic              score_ready_i;
  logic [DATA_W-1:0] score_out_o;
  logic              score_valid_o;
  logic              busy_o;
  logic              pass_done_o;
`ifdef SW_MAX_POS_EN
  logic [LEN_W-1:0]  max_pos_o;
`endif

  int checks = 0;
  int errors = 0;

  // Stimulus for one pass: per-cycle init flag and MAX value.
  bit                init_q[$];
  logic [DATA_W-1:0] max_q[$];

  // Reference model state: best score and its 1-based sample position.
  logic [DATA_W-1:0] m_acc;
  logic [LEN_W-1:0]  m_pos;

  sw_max_collector #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .new_align_i   (new_align_i),
    .last_pass_i   (last_pass_i),
    .t_len_i       (t_len_i),
    .init_in_i     (init_in_i),
    .max_in_i      (max_in_i),
    .score_ready_i (score_ready_i),
    .score_out_o   (score_out_o),
    .score_valid_o (score_valid_o),
    .busy_o        (busy_o),
    .pass_done_o   (pass_done_o)
`ifdef SW_MAX_POS_EN
    ,
    .max_pos_o     (max_pos_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic build_random(input int tl, input int gap_pct);
    int highs = 0;
    init_q.delete();
    max_q.delete();
    while (highs < tl) begin
      bit h = ($urandom_range(99) >= gap_pct);
      init_q.push_back(h);
      max_q.push_back(DATA_W'($urandom));
      if (h) highs++;
    end
  endtask

  task automatic push(input bit h, input int v);
    init_q.push_back(h);
    max_q.push_back(DATA_W'(v));
  endtask

  // Runs one pass from the current stimulus queues and checks every cycle
  // until the expected completion.
  task automatic run_pass(input bit na, input bit lp, input int tl);
    int k = 0;
    int jc = -1;
    int done_c;
    if (na) begin
      m_acc = '0;
      m_pos = '0;
    end
    if (tl > 0) begin
      for (int j = 0; j < init_q.size(); j++) begin
        if (init_q[j]) begin
          k++;
          if (max_q[j] > m_acc) begin
            m_acc = max_q[j];
            m_pos = LEN_W'(k);
          end
          if (k == tl) begin
            jc = j;
            break;
          end
        end
      end
    end
    done_c = (tl == 0) ? 0 : jc + 1;

    @(negedge clk);
    start_i     = 1'b1;
    new_align_i = na;
    last_pass_i = lp;
    t_len_i     = LEN_W'(tl);
    init_in_i   = 1'b0;
    score_ready_i = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (c == done_c) begin
        if (pass_done_o !== 1'b1 || score_valid_o !== lp || busy_o !== lp) begin
          errors++;
          $display("FAIL pass_end c=%0d: done=%b valid=%b busy=%b, want 1/%b/%b",
                   c, pass_done_o, score_valid_o, busy_o, lp, lp);
        end
        if (lp) begin
          checks++;
          if (score_out_o !== m_acc) begin
            errors++;
            $display("FAIL score: got %0d want %0d", score_out_o, m_acc);
          end
        end
`ifdef SW_MAX_POS_EN
        checks++;
        if (max_pos_o !== m_pos) begin
          errors++;
          $display("FAIL max_pos: got %0d want %0d", max_pos_o, m_pos);
        end
`endif
      end else begin
        if (pass_done_o !== 1'b0 || busy_o !== 1'b1 || score_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL in_pass c=%0d: done=%b busy=%b valid=%b, want 0/1/0",
                   c, pass_done_o, busy_o, score_valid_o);
        end
        init_in_i = (c < init_q.size()) ? init_q[c] : 1'b0;
        max_in_i  = (c < max_q.size()) ? max_q[c] : DATA_W'($urandom);
      end
    end
    // Garbage on the data inputs must be ignored in IDLE/DONE.
    init_in_i = 1'($urandom);
    max_in_i  = DATA_W'($urandom);
    @(negedge clk);
    checks++;
    if (pass_done_o !== 1'b0 || score_valid_o !== lp) begin
      errors++;
      $display("FAIL pulse_width: done=%b valid=%b, want 0/%b", pass_done_o, score_valid_o, lp);
    end
  endtask

  // Holds the result in DONE for a while (with ignored start pulses), then
  // completes the handshake and expects a return to IDLE.
  task automatic handshake(input int hold);
    for (int i = 0; i < hold; i++) begin
      start_i       = 1'($urandom);
      new_align_i   = 1'b1;
      t_len_i       = LEN_W'($urandom_range(0, 3));
      init_in_i     = 1'($urandom);
      max_in_i      = DATA_W'($urandom);
      score_ready_i = 1'b0;
      @(negedge clk);
      checks++;
      if (score_valid_o !== 1'b1 || score_out_o !== m_acc || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL hold i=%0d: valid=%b score=%0d busy=%b, want 1/%0d/1",
                 i, score_valid_o, score_out_o, busy_o, m_acc);
      end
    end
    start_i       = 1'b0;
    score_ready_i = 1'b1;
    @(negedge clk);
    score_ready_i = 1'b0;
    checks++;
    if (score_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL release: valid=%b busy=%b, want 0/0", score_valid_o, busy_o);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (score_out_o !== '0 || score_valid_o !== 1'b0 || busy_o !== 1'b0 || pass_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: score=%0d valid=%b busy=%b done=%b, want all 0",
               score_out_o, score_valid_o, busy_o, pass_done_o);
    end
    @(negedge clk);
    rst = 1'b0;
    m_acc = '0;
    m_pos = '0;
  endtask

  task automatic test_basic;
    init_q.delete(); max_q.delete();
    push(1, 3); push(1, 9); push(1, 9); push(1, 12);
    run_pass(1'b1, 1'b1, 4);
    handshake(2);
  endtask

  task automatic test_two_pass;
    init_q.delete(); max_q.delete();
    push(1, 5); push(1, 20); push(1, 20);
    run_pass(1'b1, 1'b0, 3);
    init_q.delete(); max_q.delete();
    push(1, 7); push(1, 15); push(1, 15);
    run_pass(1'b0, 1'b1, 3);
    handshake(1);
  endtask

  task automatic test_gaps;
    init_q.delete(); max_q.delete();
    push(1, 100); push(0, 4000); push(0, 4001); push(1, 50); push(0, 4002); push(1, 200);
    run_pass(1'b1, 1'b1, 3);
    handshake(5);
  endtask

  task automatic test_zero_len;
    init_q.delete(); max_q.delete();
    run_pass(1'b1, 1'b1, 0);
    handshake(1);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start_i = 1'b1; new_align_i = 1'b1; last_pass_i = 1'b1; t_len_i = LEN_W'(4);
    @(negedge clk);
    start_i = 1'b0; init_in_i = 1'b1; max_in_i = DATA_W'(4000);
    @(negedge clk);
    max_in_i = DATA_W'(4050);
    @(negedge clk);
    init_in_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (score_out_o !== '0 || score_valid_o !== 1'b0 || busy_o !== 1'b0 || pass_done_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: score=%0d valid=%b busy=%b done=%b, want all 0",
               score_out_o, score_valid_o, busy_o, pass_done_o);
    end
`ifdef SW_MAX_POS_EN
    checks++;
    if (max_pos_o !== '0) begin
      errors++;
      $display("FAIL async_reset_pos: got %0d want 0", max_pos_o);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    m_acc = '0;
    m_pos = '0;
    init_q.delete(); max_q.delete();
    push(1, 10); push(1, 30); push(1, 20); push(1, 25);
    run_pass(1'b0, 1'b1, 4);
    handshake(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      bit na = (i == 0) ? 1'b1 : 1'($urandom);
      bit lp = 1'($urandom);
      int tl = $urandom_range(0, 8);
      build_random(tl, $urandom_range(0, 60));
      run_pass(na, lp, tl);
      if (lp) handshake($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0; new_align_i = 1'b0; last_pass_i = 1'b0; t_len_i = '0;
    init_in_i = 1'b0; max_in_i = '0; score_ready_i = 1'b0;
    test_reset;
    test_basic;
    test_two_pass;
    test_gaps;
    test_zero_len;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_max_collector.md
SW_MAX_COLLECTOR -- requirements
Module: sw_max_collector

Interface
REQ-001 Parameter DATA_W, default 12, SHALL set the score width, matching the PE chain MAX/V width.
REQ-002 Parameter LEN_W, default 10, SHALL set the width of the T-length and position fields.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 start  input  1  SHALL be a one-cycle pulse that begins collection of one stripe pass.
REQ-006 new_align  input  1  SHALL, when sampled with start, clear the accumulated score before the pass.
REQ-007 last_pass  input  1  SHALL, when sampled with start, mark the pass as the final stripe of the alignment.
REQ-008 t_len  input  LEN_W  SHALL give the number of valid T characters per pass, sampled with start.
REQ-009 init_in  input  1  SHALL be the last PE's init_out, high for cycles carrying valid data.
REQ-010 MAX_in  input  DATA_W  SHALL be the last PE's MAX_out, an unsigned non-negative running maximum.
REQ-011 score_ready  input  1  SHALL be the consumer's acceptance of score_out.
REQ-012 score_out  output  DATA_W  SHALL hold the final alignment score.
REQ-013 score_valid  output  1  SHALL indicate score_out is valid.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.
REQ-015 pass_done  output  1  SHALL pulse for one cycle when a pass completes.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, WAIT, COLLECT, DONE.
REQ-017 IDLE with start=1 SHALL latch t_len/last_pass, clear the sample counter, clear acc if new_align=1, and enter WAIT; start outside IDLE SHALL be ignored.
REQ-018 WAIT SHALL enter COLLECT on the first cycle with init_in=1; that cycle SHALL count as sample 1.
REQ-019 In WAIT/COLLECT each cycle with init_in=1 SHALL increment the 10-bit counter and capture acc <= unsigned max(acc, MAX_in); init_in=0 cycles SHALL be gaps, neither counted nor captured.
REQ-020 On the cycle the t_len-th sample is captured, pass_done SHALL assert the next cycle; next state DONE if last_pass latched, else IDLE.
REQ-021 t_len=0 SHALL complete the pass one cycle after start with acc unchanged, without waiting for init_in.
REQ-022 MAX_in and init_in SHALL be ignored in IDLE and DONE.
REQ-023 In DONE, score_valid=1 and score_out=acc SHALL be held stable until score_valid&score_ready, after which the FSM SHALL return to IDLE the next cycle with score_valid=0.
REQ-024 Latency from final sample to score_valid SHALL be exactly one cycle.
REQ-025 acc SHALL persist across non-final passes so the score is the max over all stripes.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, acc=0, counter=0, score_out=0, score_valid=0, busy=0, pass_done=0 (and max_pos=0), including mid-pass; no pending result SHALL survive.

Configuration
REQ-027 Macro SW_MAX_POS_EN, when defined, SHALL add output max_pos [LEN_W-1:0]: sample index (1-based, counted across the pass) at which acc last strictly increased, cleared with acc, held with score_out in DONE.
REQ-028 Without SW_MAX_POS_EN, max_pos and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 new_align=1,last_pass=1,t_len=4, init_in=1 for 4 cycles with MAX_in 3,9,9,12 -> score_valid one cycle after 4th sample, score_out=12, max_pos=4, pass_done one pulse.
REQ-030 Two passes t_len=3: pass1 (new_align=1) MAX ends 20, pass2 (last_pass=1) MAX ends 15 -> score_out=20; pass_done pulses twice; score_valid only after pass2.
REQ-031 t_len=3 with init_in pattern 1,0,0,1,0,1 -> completion only after the 3rd high cycle; gaps not counted.
REQ-032 DONE with score_ready=0 for 5 cycles, then 1; start pulsed during DONE -> score_out stable, start ignored, IDLE one cycle after handshake.
REQ-033 rst asserted mid-COLLECT after 2 of 4 samples -> all outputs 0 asynchronously; a following full pass produces only its own score.
REQ-034 start with t_len=0, last_pass=1, new_align=1 -> score_valid next cycle, score_out=0.
